// File: rtl/apl_pkg.sv
// Shared sizing, typedefs and address helpers for the host request tagger.
package apl_pkg;

  localparam int nstrms           = 64;
  localparam int nstrms_width     = $clog2(nstrms);
  localparam int addr_width       = 64;
  localparam int cache_line       = 128;
  localparam int cache_line_width = $clog2(cache_line);
  localparam int ntags            = 16;
  localparam int tag_width        = $clog2(ntags);

  typedef logic [tag_width-1:0]    tag_t;
  typedef logic [nstrms_width-1:0] sid_t;
  typedef logic [addr_width-1:0]   ea_t;
  typedef logic [tag_width:0]      cnt_t;

  // Clear the byte-offset bits so the host sees a whole-line read.
  function automatic ea_t line_align(input ea_t ea);
    line_align = ea & ~ea_t'((1 << cache_line_width) - 1);
  endfunction

endpackage

// File: rtl/apl_tag_alloc.sv
// Host tag pool: lowest-free allocation, release on response, outstanding count.
module apl_tag_alloc
  import apl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic alloc_v,
  output tag_t alloc_tag,
  input  logic free_v,
  input  tag_t free_tag,
  output logic full,
  output logic busy_of,
  output cnt_t count
);

  localparam cnt_t cnt_one = cnt_t'(1);

  logic [ntags-1:0] busy_q;

  // Descending scan so the lowest free index wins.
  always_comb begin
    alloc_tag = '0;
    for (int i = ntags - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_tag = tag_t'(i);
    end
  end

  assign full    = &busy_q;
  assign busy_of = busy_q[free_tag];

  // Freed and allocated tags never coincide: allocation only picks tags already free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      count  <= '0;
    end else begin
      if (free_v)  busy_q[free_tag]  <= 1'b0;
      if (alloc_v) busy_q[alloc_tag] <= 1'b1;
      case ({alloc_v, free_v})
        2'b10:   count <= count + cnt_one;
        2'b01:   count <= count - cnt_one;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/apl_req_tag.sv
// Tags stream-cache line fetches for the host, issues aligned reads and
// maps out-of-order host responses back to the owning stream.
module apl_req_tag
  import apl_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req_v,
  output logic                    i_req_r,
  input  logic [nstrms_width-1:0] i_req_sid,
  input  logic [addr_width-1:0]   i_req_ea,
  output logic                    o_cmd_v,
  input  logic                    o_cmd_r,
  output logic [tag_width-1:0]    o_cmd_tag,
  output logic [addr_width-1:0]   o_cmd_ea,
  input  logic                    i_resp_v,
  output logic                    i_resp_r,
  input  logic [tag_width-1:0]    i_resp_tag,
  output logic                    o_rsp_v,
  input  logic                    o_rsp_r,
  output logic [nstrms_width-1:0] o_rsp_sid,
  output logic [tag_width:0]      o_outstanding,
  output logic                    o_idle,
  output logic                    o_err
);

  logic alloc_v, free_v, full, busy_of, resp_fire;
  tag_t alloc_tag;
  cnt_t count;

  logic cmd_vld_p1, rsp_vld_p1, err_q;
  tag_t cmd_tag_p1;
  ea_t  cmd_ea_p1;
  sid_t rsp_sid_p1;
  sid_t sid_tab [ntags];

  assign i_req_r   = !full && (!cmd_vld_p1 || o_cmd_r);
  assign alloc_v   = i_req_v && i_req_r;
  assign i_resp_r  = !rsp_vld_p1 || o_rsp_r;
  assign resp_fire = i_resp_v && i_resp_r;
  assign free_v    = resp_fire && busy_of;

  apl_tag_alloc u_alloc (
    .clk       (clk),
    .reset     (reset),
    .alloc_v   (alloc_v),
    .alloc_tag (alloc_tag),
    .free_v    (free_v),
    .free_tag  (i_resp_tag),
    .full      (full),
    .busy_of   (busy_of),
    .count     (count)
  );

  // Stage p1: host command register, holds while the host stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_vld_p1 <= 1'b0;
      cmd_tag_p1 <= '0;
      cmd_ea_p1  <= '0;
      for (int i = 0; i < ntags; i++) sid_tab[i] <= '0;
    end else begin
      if (alloc_v) begin
        cmd_vld_p1         <= 1'b1;
        cmd_tag_p1         <= alloc_tag;
        cmd_ea_p1          <= line_align(i_req_ea);
        sid_tab[alloc_tag] <= i_req_sid;
      end else if (o_cmd_r) begin
        cmd_vld_p1 <= 1'b0;
      end
    end
  end

  // Stage p1: response register toward the stream cache; stray tags only raise o_err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_vld_p1 <= 1'b0;
      rsp_sid_p1 <= '0;
      err_q      <= 1'b0;
    end else begin
      if (free_v) begin
        rsp_vld_p1 <= 1'b1;
        rsp_sid_p1 <= sid_tab[i_resp_tag];
      end else if (o_rsp_r) begin
        rsp_vld_p1 <= 1'b0;
      end
      if (resp_fire && !busy_of) err_q <= 1'b1;
    end
  end

  assign o_cmd_v       = cmd_vld_p1;
  assign o_cmd_tag     = cmd_tag_p1;
  assign o_cmd_ea      = cmd_ea_p1;
  assign o_rsp_v       = rsp_vld_p1;
  assign o_rsp_sid     = rsp_sid_p1;
  assign o_outstanding = count;
  assign o_err         = err_q;
  assign o_idle        = (count == '0) && !cmd_vld_p1 && !rsp_vld_p1;

endmodule

// File: tb/tb_apl_req_tag.sv
// Directed bench for apl_req_tag with a tag-pool reference model checked every cycle.
module tb_apl_req_tag;
  import apl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req_v = 1'b0, i_req_r;
  logic [5:0]  i_req_sid = '0;
  logic [63:0] i_req_ea = '0;
  logic        o_cmd_v, o_cmd_r = 1'b1;
  logic [3:0]  o_cmd_tag;
  logic [63:0] o_cmd_ea;
  logic        i_resp_v = 1'b0, i_resp_r;
  logic [3:0]  i_resp_tag = '0;
  logic        o_rsp_v, o_rsp_r = 1'b1;
  logic [5:0]  o_rsp_sid;
  logic [4:0]  o_outstanding;
  logic        o_idle, o_err;

  int checks = 0;
  int failures = 0;

  apl_req_tag dut (
    .clk(clk), .reset(reset),
    .i_req_v(i_req_v), .i_req_r(i_req_r), .i_req_sid(i_req_sid), .i_req_ea(i_req_ea),
    .o_cmd_v(o_cmd_v), .o_cmd_r(o_cmd_r), .o_cmd_tag(o_cmd_tag), .o_cmd_ea(o_cmd_ea),
    .i_resp_v(i_resp_v), .i_resp_r(i_resp_r), .i_resp_tag(i_resp_tag),
    .o_rsp_v(o_rsp_v), .o_rsp_r(o_rsp_r), .o_rsp_sid(o_rsp_sid),
    .o_outstanding(o_outstanding), .o_idle(o_idle), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: set of owned tags with their stream, plus the two pending outputs.
  bit          m_busy [16];
  logic [5:0]  m_sid  [16];
  bit          m_cmd_v, m_rsp_v, m_err;
  logic [3:0]  m_cmd_tag;
  logic [63:0] m_cmd_ea;
  logic [5:0]  m_rsp_sid;
  int          m_atag;
  bit          m_req_ok, m_resp_ok;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
      m_cmd_v = 0; m_rsp_v = 0; m_err = 0;
    end else begin
      m_req_ok  = i_req_v && (m_count() < 16) && (!m_cmd_v || o_cmd_r);
      m_resp_ok = i_resp_v && (!m_rsp_v || o_rsp_r);
      m_atag = -1;
      for (int i = 0; i < 16; i++) if (m_atag < 0 && !m_busy[i]) m_atag = i;
      if (o_rsp_r) m_rsp_v = 0;
      if (m_resp_ok) begin
        if (m_busy[i_resp_tag]) begin
          m_rsp_v = 1;
          m_rsp_sid = m_sid[i_resp_tag];
          m_busy[i_resp_tag] = 0;
        end else begin
          m_err = 1;
        end
      end
      if (o_cmd_r) m_cmd_v = 0;
      if (m_req_ok) begin
        m_busy[m_atag] = 1;
        m_sid[m_atag] = i_req_sid;
        m_cmd_v = 1;
        m_cmd_tag = 4'(m_atag);
        m_cmd_ea = i_req_ea & ~64'h7F;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("cmd_v", o_cmd_v, m_cmd_v);
      if (m_cmd_v) begin
        chk("cmd_tag", o_cmd_tag, m_cmd_tag);
        chk("cmd_ea", o_cmd_ea, m_cmd_ea);
      end
      chk("rsp_v", o_rsp_v, m_rsp_v);
      if (m_rsp_v) chk("rsp_sid", o_rsp_sid, m_rsp_sid);
      chk("err", o_err, m_err);
      chk("outstanding", o_outstanding, 64'(m_count()));
      chk("idle", o_idle, (m_count() == 0) && !m_cmd_v && !m_rsp_v);
      chk("req_r", i_req_r, (m_count() < 16) && (!m_cmd_v || o_cmd_r));
      chk("resp_r", i_resp_r, !m_rsp_v || o_rsp_r);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic samp();
    @(negedge clk); #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cmd_v"}, o_cmd_v, 0);
    chk({tag, "_rsp_v"}, o_rsp_v, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_idle"}, o_idle, 1);
    chk({tag, "_outst"}, o_outstanding, 0);
    chk({tag, "_cmd_tag"}, o_cmd_tag, 0);
    chk({tag, "_cmd_ea"}, o_cmd_ea, 0);
    chk({tag, "_rsp_sid"}, o_rsp_sid, 0);
  endtask

  initial begin
    #2 reset = 1'b0;
    step(); step();
    #1 chk_reset_state("rst0");
    step();
    reset = 1'b1;

    // 1: single request and its response
    i_req_v = 1; i_req_sid = 6'd1; i_req_ea = 64'h883;
    step(); i_req_v = 0;
    samp();
    chk("t1_cmd_v", o_cmd_v, 1);
    chk("t1_cmd_tag", o_cmd_tag, 0);
    chk("t1_cmd_ea", o_cmd_ea, 64'h880);
    i_resp_v = 1; i_resp_tag = 4'd0;
    step(); i_resp_v = 0;
    samp();
    chk("t1_rsp_v", o_rsp_v, 1);
    chk("t1_rsp_sid", o_rsp_sid, 1);
    step(); samp();
    chk("t1_idle", o_idle, 1);

    // 2: fill all 16 tags, then free tag 5 and reuse it
    i_req_v = 1;
    for (int i = 0; i < 16; i++) begin
      i_req_sid = 6'(i); i_req_ea = 64'(i * 256 + 5);
      step(); samp();
      chk("t2_tag", o_cmd_tag, 64'(i));
    end
    i_req_sid = 6'd16;
    chk("t2_full_req_r", i_req_r, 0);
    chk("t2_full_outst", o_outstanding, 16);
    i_resp_v = 1; i_resp_tag = 4'd5;
    step(); i_resp_v = 0; i_req_sid = 6'd20;
    samp();
    chk("t2_req_r_after_free", i_req_r, 1);
    chk("t2_rsp_sid5", o_rsp_sid, 5);
    step(); i_req_v = 0;
    samp();
    chk("t2_reuse_tag", o_cmd_tag, 5);
    for (int t = 0; t < 16; t++) begin
      i_resp_v = 1; i_resp_tag = 4'(t);
      step();
    end
    i_resp_v = 0;
    step(); samp();
    chk("t2_drained", o_idle, 1);

    // 3: out-of-order return
    i_req_v = 1;
    i_req_sid = 6'd7; step();
    i_req_sid = 6'd9; step();
    i_req_sid = 6'd3; step();
    i_req_v = 0;
    i_resp_v = 1; i_resp_tag = 4'd2; step(); samp();
    chk("t3_sid_a", o_rsp_sid, 3);
    i_resp_tag = 4'd0; step(); samp();
    chk("t3_sid_b", o_rsp_sid, 7);
    i_resp_tag = 4'd1; step(); i_resp_v = 0; samp();
    chk("t3_sid_c", o_rsp_sid, 9);
    step(); step();

    // 4: command and response backpressure
    o_cmd_r = 0;
    i_req_v = 1; i_req_sid = 6'd4; i_req_ea = 64'h1234;
    step();
    i_req_sid = 6'd5; i_req_ea = 64'h5678;
    for (int c = 0; c < 4; c++) begin
      samp();
      chk("t4_hold_tag", o_cmd_tag, 0);
      chk("t4_hold_ea", o_cmd_ea, 64'h1200);
      chk("t4_req_r", i_req_r, 0);
      step();
    end
    o_cmd_r = 1;
    samp();
    chk("t4_req_r_release", i_req_r, 1);
    step(); i_req_v = 0;
    samp();
    chk("t4_next_tag", o_cmd_tag, 1);
    chk("t4_next_ea", o_cmd_ea, 64'h5600);
    o_rsp_r = 0;
    i_resp_v = 1; i_resp_tag = 4'd0;
    step(); i_resp_tag = 4'd1;
    for (int c = 0; c < 3; c++) begin
      samp();
      chk("t4_resp_r", i_resp_r, 0);
      chk("t4_rsp_hold", o_rsp_sid, 4);
      step();
    end
    o_rsp_r = 1;
    samp();
    chk("t4_resp_r_release", i_resp_r, 1);
    step(); i_resp_v = 0;
    samp();
    chk("t4_rsp_sid", o_rsp_sid, 5);
    step(); step(); samp();
    chk("t4_idle", o_idle, 1);

    // 5: same-cycle free and allocate
    i_req_v = 1;
    for (int i = 0; i < 4; i++) begin
      i_req_sid = 6'(10 + i); step();
    end
    i_req_sid = 6'd14;
    i_resp_v = 1; i_resp_tag = 4'd3;
    samp();
    chk("t5_outst_before", o_outstanding, 4);
    step(); i_req_v = 0; i_resp_v = 0;
    samp();
    chk("t5_new_tag", o_cmd_tag, 4);
    chk("t5_outst_after", o_outstanding, 4);
    chk("t5_rsp_sid", o_rsp_sid, 13);

    // 6: stray response, sticky error, reset mid-operation
    i_resp_v = 1; i_resp_tag = 4'd4; step();
    i_resp_tag = 4'd9; step(); i_resp_v = 0;
    samp();
    chk("t6_no_rsp", o_rsp_v, 0);
    chk("t6_err", o_err, 1);
    step(); step(); step(); samp();
    chk("t6_err_sticky", o_err, 1);
    chk("t6_outst3", o_outstanding, 3);
    #2 reset = 1'b0;
    #1 chk_reset_state("rst1");
    step(); step();
    reset = 1'b1;
    i_resp_v = 1; i_resp_tag = 4'd0; step(); i_resp_v = 0;
    samp();
    chk("t6_old_tag_no_rsp", o_rsp_v, 0);
    chk("t6_old_tag_err", o_err, 1);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apl_req_tag.md
Name: apl_req_tag

Overview:
- Sits between the stream cache request/response ports (o_req_*/i_rsp_*) and the OpenCAPI 3.0 host command/response interface.
- Assigns a host tag to each cache-line fetch request and records the requesting stream ID per tag.
- Issues cache-line-aligned read commands to the host.
- Accepts out-of-order host responses and returns the owning stream ID to the stream cache.

Parameters:
nstrms, 64, number of streams; nstrms_width = $clog2(nstrms)
addr_width, 64, host effective address width in bits
cache_line, 128, host cache line in bytes; cache_line_width = $clog2(cache_line)
ntags, 16, maximum outstanding host reads; tag_width = $clog2(ntags)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low (asserted at 0)
i_req_v  input  1  fetch request valid, from stream cache o_req_v
i_req_r  output  1  fetch request ready
i_req_sid  input  nstrms_width  requesting stream
i_req_ea  input  addr_width  requested effective address
o_cmd_v  output  1  host read command valid
o_cmd_r  input  1  host command ready
o_cmd_tag  output  tag_width  assigned tag
o_cmd_ea  output  addr_width  i_req_ea with low cache_line_width bits forced to 0
i_resp_v  input  1  host response valid
i_resp_r  output  1  host response ready
i_resp_tag  input  tag_width  tag of returning line
o_rsp_v  output  1  response valid, to stream cache i_rsp_v
o_rsp_r  input  1  stream cache ready
o_rsp_sid  output  nstrms_width  stream owning the returned line
o_outstanding  output  tag_width+1  number of allocated tags
o_idle  output  1  no tags allocated, no valid output
o_err  output  1  sticky: response received for an unallocated tag

Behaviour:
- Reset asserted, asynchronous: all tags free; tag table cleared; counter 0.
  - o_cmd_v=0, o_rsp_v=0, o_err=0, o_idle=1, o_outstanding=0; all data outputs 0.
  - Reset mid-operation discards every in-flight command and response. No response is ever produced for a tag issued before reset.
- Allocation: free mask of ntags bits; the lowest-index free tag is chosen.
- i_req_r = (any tag free) && (!o_cmd_v || o_cmd_r).
- On i_req_v && i_req_r:
  - tag marked busy; sid written into table[tag].
  - Command register loaded; o_cmd_v high in the next cycle. Latency 1.
- Command register holds tag/ea stable while o_cmd_v && !o_cmd_r. It is a back-to-back throughput-1 skid-free register.
- Response path: i_resp_r = !o_rsp_v || o_rsp_r.
- On i_resp_v && i_resp_r with the tag busy:
  - table[tag] is loaded into the o_rsp register; o_rsp_v rises next cycle (latency 1).
  - Tag is freed at the same edge and is allocatable the following cycle.
- On i_resp_v && i_resp_r with the tag not busy:
  - Response is dropped; o_rsp_v is not asserted.
  - o_err is set and stays set until reset.
- Same-cycle allocate and free: allowed. The freed tag cannot equal the allocated tag, because allocation selects only from tags that were already free. Counter net change is 0.
- o_outstanding: +1 on allocate, -1 on legal free, never exceeds ntags. Full: i_req_r=0 while o_outstanding==ntags.
- o_idle = (o_outstanding==0) && !o_cmd_v && !o_rsp_v.
- Responses may return in any order. o_rsp ordering follows host response order, not request order.

Decomposition:
- Package apl_pkg holds:
  - nstrms, addr_width, cache_line, ntags defaults and their derived widths;
  - the tag_t and sid_t typedefs;
  - a function for cache-line alignment of an EA.
- Sub-module apl_tag_alloc contains the free mask, lowest-free priority encoder, free/alloc update, and outstanding counter. Ports: alloc_v, alloc_tag, free_v, free_tag, full, busy_of(tag), count.
- The top module adds the sid table and the two output registers.

Test Plan:
1. Reset, then single request sid=1 ea=0x883 with o_cmd_r=1 -> next cycle o_cmd_v=1, tag=0, ea=0x880; response tag 0 -> next cycle o_rsp_v=1, sid=1; o_idle returns to 1.
2. 16 requests sids 0..15 with no responses -> tags 0..15 issued in order; 17th request sees i_req_r=0, o_outstanding=16. Response tag 5 -> i_req_r=1 next cycle and the next request gets tag 5.
3. Out-of-order return: tags 0,1,2 (sids 7,9,3) answered as 2,0,1 -> o_rsp_sid sequence 3,7,9.
4. Backpressure: o_cmd_r=0 for 4 cycles -> o_cmd_tag/ea held stable, i_req_r=0. o_rsp_r=0 -> i_resp_r=0, o_rsp_sid held.
5. Same-cycle response for tag 3 and new request while tags 0..3 busy -> new request gets tag 4; o_outstanding unchanged.
6. Response for unallocated tag 9 -> no o_rsp_v, o_err=1 and sticky. Reset asserted with 3 outstanding -> all outputs 0, o_err=0, o_idle=1, o_outstanding=0.
